adder_meas_sequencer: RTL

- Host-side driver and reader for an instrumented adder under test; it is the other end of the adder's operand/measurement interface.
- Accepts a measurement command (operands plus gate length), drives operands and ring/counter controls into the adder, then captures the ring-oscillator count and the sum.
- Checks the sum against a reference addition and returns the result on a valid/ready response channel.
- Sits between a logic-analyser/wishbone register front end and the wrapped adder.

---
 rtl/adder_meas_pkg.sv | 26 ++
 rtl/meas_window_counter.sv | 27 ++
 rtl/adder_meas_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/adder_meas_pkg.sv
// rtl/adder_meas_pkg.sv - shared types and default widths for the adder measurement sequencer
package adder_meas_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_CNT_W      = 32;
    localparam int DEF_GATE_W     = 16;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_SYNC_CYC   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_GATE,
        ST_SYNC,
        ST_RESP
    } meas_state_t;

    typedef struct packed {
        logic [DEF_CNT_W-1:0] count;
        logic [DEF_WIDTH-1:0] sum;
        logic                 carry;
        logic                 err;
    } meas_rsp_t;

endpackage

// File: rtl/meas_window_counter.sv
// rtl/meas_window_counter.sv - loadable down-counter timing the settle, gate and sync windows
module meas_window_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    // Loading N-1 on phase entry makes o_done rise on the phase's Nth cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/adder_meas_sequencer.sv
// rtl/adder_meas_sequencer.sv - drives the instrumented adder, gates its ring count and checks the sum
module adder_meas_sequencer
    import adder_meas_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GATE_W     = DEF_GATE_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int SYNC_CYC   = DEF_SYNC_CYC
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [WIDTH-1:0]  cmd_a,
    input  logic [WIDTH-1:0]  cmd_b,
    input  logic [GATE_W-1:0] cmd_gate,
    input  logic              abort,
    output logic [WIDTH-1:0]  dut_a,
    output logic [WIDTH-1:0]  dut_b,
    output logic              dut_ring_en,
    output logic              dut_cnt_clr,
    output logic              dut_cnt_en,
    input  logic [CNT_W-1:0]  dut_count,
    input  logic [WIDTH-1:0]  dut_sum,
    input  logic              dut_carry,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CNT_W-1:0]  rsp_count,
    output logic [WIDTH-1:0]  rsp_sum,
    output logic              rsp_carry,
    output logic              rsp_err,
    output logic              busy
);

    meas_state_t       r_state;
    meas_state_t       w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [GATE_W-1:0] r_gate;
    logic              w_load;
    logic [GATE_W-1:0] w_load_val;
    logic              w_done;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_ring_en;
    logic              r_cnt_clr;
    logic              r_cnt_en;
    logic              r_rsp_valid;
    meas_rsp_t         r_rsp;

    meas_window_counter #(
        .W(GATE_W)
    ) u_window (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // The window counter is reloaded on the last cycle of each phase for the next one.
    always_comb begin
        w_next     = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_load     = 1'b1;
                w_load_val = GATE_W'(SETTLE_CYC - 1);
                w_next     = abort ? ST_IDLE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_done) begin
                    w_next     = ST_GATE;
                    w_load     = 1'b1;
                    w_load_val = r_gate - GATE_W'(1);
                end
            end
            ST_GATE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_done) begin
                    w_next     = ST_SYNC;
                    w_load     = 1'b1;
                    w_load_val = GATE_W'(SYNC_CYC - 1);
                end
            end
            ST_SYNC: begin
                if (abort) w_next = ST_IDLE;
                else if (w_done) w_next = ST_RESP;
            end
            ST_RESP: begin
                if (abort || (r_rsp_valid && rsp_ready)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with the state it belongs to.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_ring_en   <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cmd_ready <= (w_next == ST_IDLE);
            r_busy      <= (w_next != ST_IDLE);
            r_ring_en   <= (w_next == ST_LOAD) || (w_next == ST_SETTLE) ||
                           (w_next == ST_GATE) || (w_next == ST_SYNC);
            r_cnt_clr   <= (w_next == ST_LOAD);
            r_cnt_en    <= (w_next == ST_GATE);
            r_rsp_valid <= (w_next == ST_RESP);
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_a    <= '0;
            r_b    <= '0;
            r_gate <= '0;
        end else if ((r_state == ST_IDLE) && cmd_valid) begin
            r_a    <= cmd_a;
            r_b    <= cmd_b;
            r_gate <= (cmd_gate == '0) ? GATE_W'(1) : cmd_gate;
        end
    end

    // Reference check uses the full WIDTH+1 result so a lost carry is flagged.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_rsp <= '0;
        end else if ((r_state == ST_SYNC) && (w_next == ST_RESP)) begin
            r_rsp.count <= dut_count;
            r_rsp.sum   <= dut_sum;
            r_rsp.carry <= dut_carry;
            r_rsp.err   <= ({dut_carry, dut_sum} != ({1'b0, r_a} + {1'b0, r_b}));
        end
    end

    assign cmd_ready   = r_cmd_ready;
    assign busy        = r_busy;
    assign dut_a       = r_a;
    assign dut_b       = r_b;
    assign dut_ring_en = r_ring_en;
    assign dut_cnt_clr = r_cnt_clr;
    assign dut_cnt_en  = r_cnt_en;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_count   = r_rsp.count;
    assign rsp_sum     = r_rsp.sum;
    assign rsp_carry   = r_rsp.carry;
    assign rsp_err     = r_rsp.err;

endmodule
